// File: rtl/clk_gate_ctrl.sv
// Automatic clock-gating controller: one RUN/OFF/WAKE FSM per domain drives the ICG enable,
// closing a clock after a run of idle cycles and reopening it on request with a settle delay.
module clk_gate_ctrl #(
    parameter int unsigned NumDomains  = 4,
    parameter int unsigned IdleThresh  = 16,
    parameter int unsigned WakeLatency = 2,
    parameter int unsigned CntWidth    =
        $clog2(((IdleThresh > WakeLatency) ? IdleThresh : WakeLatency) + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  force_on_i,
    input  logic [NumDomains-1:0] gate_allow_i,
    input  logic [NumDomains-1:0] busy_i,
    input  logic [NumDomains-1:0] req_i,
    output logic [NumDomains-1:0] ready_o,
    output logic [NumDomains-1:0] en_o,
    output logic                  all_gated_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        OFF  = 2'd1,
        WAKE = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleThresh - 1);
    localparam logic [CntWidth-1:0] WakeLast =
        (WakeLatency > 0) ? CntWidth'(WakeLatency - 1) : '0;

    state_e              state_q [NumDomains];
    state_e              state_d [NumDomains];
    logic [CntWidth-1:0] cnt_q   [NumDomains];
    logic [CntWidth-1:0] cnt_d   [NumDomains];

    logic [NumDomains-1:0] keep;
    logic [NumDomains-1:0] wake;
    logic [NumDomains-1:0] en_d;
    logic [NumDomains-1:0] ready_d;

    assign wake = req_i | {NumDomains{force_on_i}} | ~gate_allow_i;
    assign keep = wake | busy_i;

    always_comb begin
        en_d    = '0;
        ready_d = '0;
        for (int unsigned i = 0; i < NumDomains; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                RUN: begin
                    if (keep[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == IdleLast) begin
                        state_d[i] = OFF;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                OFF: begin
                    if (wake[i]) begin
                        state_d[i] = (WakeLatency == 0) ? RUN : WAKE;
                        cnt_d[i]   = '0;
                    end
                end
                WAKE: begin
                    // Not abortable: inputs are ignored until the settle delay expires.
                    if (cnt_q[i] == WakeLast) begin
                        state_d[i] = RUN;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = RUN;
                    cnt_d[i]   = '0;
                end
            endcase
            // Outputs are decoded from next state so they leave their own flops.
            en_d[i]    = (state_d[i] != OFF);
            ready_d[i] = (state_d[i] == RUN);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumDomains; i++) begin
                state_q[i] <= RUN;
                cnt_q[i]   <= '0;
            end
            en_o        <= '1;
            ready_o     <= '1;
            all_gated_o <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NumDomains; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            en_o        <= en_d;
            ready_o     <= ready_d;
            all_gated_o <= ~|en_o;
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: default build plus a 2-domain WakeLatency=0 build.
module tb_clk_gate_ctrl;

    typedef struct {
        string      name;
        int         dsel;
        int         cyc;
        logic [3:0] m;
        logic [3:0] en;
        logic [3:0] rdy;
        logic       agc;
        logic       ag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       force_on;
    logic [3:0] gate_allow, busy, req, ready, en;
    logic       all_gated;
    logic       force1;
    logic [1:0] gate_allow1, busy1, req1, ready1, en1;
    logic       all_gated1;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_gate_ctrl #(
        .NumDomains (4),
        .IdleThresh (16),
        .WakeLatency(2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .force_on_i  (force_on),
        .gate_allow_i(gate_allow),
        .busy_i      (busy),
        .req_i       (req),
        .ready_o     (ready),
        .en_o        (en),
        .all_gated_o (all_gated)
    );

    clk_gate_ctrl #(
        .NumDomains (2),
        .IdleThresh (4),
        .WakeLatency(0)
    ) dut_wl0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .force_on_i  (force1),
        .gate_allow_i(gate_allow1),
        .busy_i      (busy1),
        .req_i       (req1),
        .ready_o     (ready1),
        .en_o        (en1),
        .all_gated_o (all_gated1)
    );

    function automatic void push_exp(string name, int dsel, int c, logic [3:0] m,
                                     logic [3:0] e, logic [3:0] r, logic agc, logic ag);
        exp_t x;
        x.name = name; x.dsel = dsel; x.cyc = c; x.m = m;
        x.en = e; x.rdy = r; x.agc = agc; x.ag = ag;
        sb.push_back(x);
    endfunction

    function automatic void check_one(exp_t e);
        logic [3:0] ae, ar;
        logic       ag;
        if (e.dsel == 0) begin
            ae = en; ar = ready; ag = all_gated;
        end else begin
            ae = {2'b00, en1}; ar = {2'b00, ready1}; ag = all_gated1;
        end
        n_cmp++;
        if (((ae & e.m) !== (e.en & e.m)) || ((ar & e.m) !== (e.rdy & e.m)) ||
            (e.agc && (ag !== e.ag))) begin
            n_bad++;
            $display("FAIL %s cyc=%0d mask=%b en=%b want %b ready=%b want %b all_gated=%b want %b",
                     e.name, cyc, e.m, ae, e.en, ar, e.rdy, ag, e.agc ? e.ag : ag);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t rest[$];
        rest = {};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cyc == cyc) begin
                check_one(e);
            end else if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s missed cycle %0d (now %0d)", e.name, e.cyc, cyc);
            end else begin
                rest.push_back(e);
            end
        end
        sb = rest;
    end

    task automatic ticks(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst_n = 1'b0; force_on = 1'b0; gate_allow = 4'hF; busy = '0; req = '0;
        force1 = 1'b0; gate_allow1 = 2'b11; busy1 = '0; req1 = '0;

        // Reset values, then idle gating after release.
        ticks(3);
        push_exp("reset",     0, cyc, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        push_exp("reset_wl0", 1, cyc, 4'h3, 4'h3, 4'h3, 1'b1, 1'b0);
        rst_n = 1'b1;
        t = cyc;
        push_exp("wl0_idle3",  1, t + 3,  4'h3, 4'h3, 4'h3, 1'b0, 1'b0);
        push_exp("wl0_gate4",  1, t + 4,  4'h3, 4'h0, 4'h0, 1'b0, 1'b0);
        push_exp("idle15",     0, t + 15, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        push_exp("gate16",     0, t + 16, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        push_exp("allgated17", 0, t + 17, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1);
        ticks(20);

        // One-cycle force wakes all; busy[1] pulse at idle cycle 10 restarts domain 1.
        t = cyc;
        force_on = 1'b1;
        push_exp("force_en",    0, t + 1,  4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        push_exp("force_wait",  0, t + 2,  4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        push_exp("force_ready", 0, t + 3,  4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        push_exp("restart_pre", 0, t + 18, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        push_exp("restart_gate",0, t + 19, 4'hF, 4'h2, 4'h2, 1'b0, 1'b0);
        push_exp("d1_hold",     0, t + 29, 4'hF, 4'h2, 4'h2, 1'b0, 1'b0);
        push_exp("d1_gate",     0, t + 30, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        push_exp("d1_allgated", 0, t + 31, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1);
        ticks(1);
        force_on = 1'b0;
        ticks(12);
        busy[1] = 1'b1;
        ticks(1);
        busy[1] = 1'b0;
        ticks(21);

        // Wake handshake on domain 2; WakeLatency=0 wake on the second build.
        t = cyc;
        req[2]  = 1'b1;
        req1[0] = 1'b1;
        push_exp("d2_off",      0, t,      4'h4, 4'h0, 4'h0, 1'b0, 1'b0);
        push_exp("wl0_off",     1, t,      4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
        push_exp("d2_en",       0, t + 1,  4'h4, 4'h4, 4'h0, 1'b0, 1'b0);
        push_exp("wl0_same",    1, t + 1,  4'h3, 4'h1, 4'h1, 1'b0, 1'b0);
        push_exp("d2_settle",   0, t + 2,  4'h4, 4'h4, 4'h0, 1'b1, 1'b0);
        push_exp("d2_ready",    0, t + 3,  4'h4, 4'h4, 4'h4, 1'b0, 1'b0);
        push_exp("d2_others",   0, t + 5,  4'hF, 4'h4, 4'h4, 1'b0, 1'b0);
        push_exp("wl0_idle",    1, t + 5,  4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
        push_exp("wl0_regate",  1, t + 6,  4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
        push_exp("d2_held",     0, t + 10, 4'h4, 4'h4, 4'h4, 1'b0, 1'b0);
        push_exp("d2_idle",     0, t + 26, 4'h4, 4'h4, 4'h4, 1'b0, 1'b0);
        push_exp("d2_regate",   0, t + 27, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0);
        ticks(2);
        req1[0] = 1'b0;
        ticks(9);
        req[2] = 1'b0;
        ticks(19);

        // busy ignored in OFF; early req drop and busy during WAKE on domain 0.
        busy[0] = 1'b1;
        push_exp("off_busy",    0, cyc + 1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
        ticks(1);
        t = cyc;
        busy[0] = 1'b0;
        req[0]  = 1'b1;
        push_exp("d0_en",       0, t + 1,  4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
        push_exp("d0_settle",   0, t + 2,  4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
        push_exp("d0_ready",    0, t + 3,  4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
        push_exp("d0_idle",     0, t + 18, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
        push_exp("d0_regate",   0, t + 19, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
        ticks(1);
        req[0]  = 1'b0;
        busy[0] = 1'b1;
        ticks(2);
        busy[0] = 1'b0;
        ticks(22);

        // Clearing gate_allow[3] wakes domain 3 and keeps it running.
        t = cyc;
        gate_allow = 4'h7;
        push_exp("d3_en",       0, t + 1,  4'hF, 4'h8, 4'h0, 1'b0, 1'b0);
        push_exp("d3_ready",    0, t + 3,  4'hF, 4'h8, 4'h8, 1'b0, 1'b0);
        push_exp("d3_never",    0, t + 40, 4'hF, 4'h8, 4'h8, 1'b1, 1'b0);
        ticks(41);

        // Reset asserted while domain 0 is in WAKE.
        t = cyc;
        req[0] = 1'b1;
        push_exp("d0_wake",     0, t + 1,  4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
        ticks(2);
        push_exp("rst_midwake", 0, cyc,    4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        push_exp("rst_wl0",     1, cyc,    4'h3, 4'h3, 4'h3, 1'b1, 1'b0);
        rst_n = 1'b0;
        ticks(2);
        rst_n      = 1'b1;
        req        = '0;
        gate_allow = 4'hF;
        ticks(5);

        if (sb.size() > 0) begin
            foreach (sb[i]) $display("FAIL %s never compared (cycle %0d)", sb[i].name, sb[i].cyc);
            n_cmp += sb.size();
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
